// File: rtl/branch_predict_ctrl_pkg.sv
// Shared types and constants for the branch predictor / recovery controller:
// FSM state encoding, 2-bit counter values and the saturating counter update.
package branch_predict_ctrl_pkg;

    localparam int WORD_W = 32;

    typedef enum logic {
        BP_RUN   = 1'b0,
        BP_FLUSH = 1'b1
    } bp_state_t;

    localparam logic [1:0] SNT = 2'b00;
    localparam logic [1:0] WNT = 2'b01;
    localparam logic [1:0] WT  = 2'b10;
    localparam logic [1:0] ST  = 2'b11;

    function automatic logic [1:0] sat_update(input logic [1:0] ctr, input logic taken);
        logic [1:0] result;
        result = ctr;
        if (taken) begin
            if (ctr != ST) result = ctr + 2'd1;
        end else begin
            if (ctr != SNT) result = ctr - 2'd1;
        end
        return result;
    endfunction

endpackage

// File: rtl/branch_predict_ctrl_bht.sv
// Branch history table of 2-bit saturating counters: one combinational read
// port (counter MSB) and one saturating write port committing at the clock edge.
module bht_2bit
    import branch_predict_ctrl_pkg::*;
#(
    parameter int INDEX_W = 6
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [INDEX_W-1:0] rd_index,
    output logic               rd_taken,
    input  logic               wr_en,
    input  logic [INDEX_W-1:0] wr_index,
    input  logic               wr_taken
);

    localparam int ENTRIES = 1 << INDEX_W;

    logic [ENTRIES-1:0] taken_bits;

    generate
        for (genvar gi = 0; gi < ENTRIES; gi++) begin : g_entry
            logic [1:0] ctr_reg;

            // Kept as discrete registers so every entry can start at weakly not-taken.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    ctr_reg <= WNT;
                end else if (wr_en && (wr_index == INDEX_W'(gi))) begin
                    ctr_reg <= sat_update(ctr_reg, wr_taken);
                end
            end

            assign taken_bits[gi] = ctr_reg[1];
        end
    endgenerate

    // No write-to-read bypass: a same-cycle update is visible only after the edge.
    assign rd_taken = taken_bits[rd_index];

endmodule

// File: rtl/branch_predict_ctrl.sv
// Branch prediction and misprediction recovery for the Execute stage: BHT
// lookup/training, RUN/FLUSH recovery sequencing and performance counters.
module branch_predict_ctrl
    import branch_predict_ctrl_pkg::*;
#(
    parameter int BHT_INDEX_W = 6,
    parameter int CNT_W       = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    input  logic [WORD_W-1:0] if_pc,
    output logic              pred_taken,
    input  logic              ex_valid,
    input  logic              ex_is_branch,
    input  logic [WORD_W-1:0] ex_br_pc,
    input  logic              ex_taken,
    input  logic              ex_correct,
    input  logic [WORD_W-1:0] ex_target,
    output logic              redirect_valid,
    output logic [WORD_W-1:0] redirect_pc,
    output logic              flush_if_id,
    output logic              flush_id_ex,
    output logic [CNT_W-1:0]  br_count,
    output logic [CNT_W-1:0]  mis_count
);

    bp_state_t         state_reg, state_next;
    logic [WORD_W-1:0] redirect_pc_reg, redirect_pc_next;
    logic [CNT_W-1:0]  br_count_reg, mis_count_reg;
    logic              ev, train_en, recover;
    logic              unused_pc_bits;

    // EX contents only count while running; anything seen during FLUSH is wrong-path.
    assign ev       = ex_valid && (state_reg == BP_RUN) && !stall;
    assign train_en = ev && ex_is_branch;
    assign recover  = ev && !ex_correct;

    bht_2bit #(
        .INDEX_W (BHT_INDEX_W)
    ) u_bht (
        .clk      (clk),
        .rst      (rst),
        .rd_index (if_pc[BHT_INDEX_W+1:2]),
        .rd_taken (pred_taken),
        .wr_en    (train_en),
        .wr_index (ex_br_pc[BHT_INDEX_W+1:2]),
        .wr_taken (ex_taken)
    );

    assign unused_pc_bits = ^{if_pc[WORD_W-1:BHT_INDEX_W+2], if_pc[1:0],
                              ex_br_pc[WORD_W-1:BHT_INDEX_W+2], ex_br_pc[1:0]};

    always_comb begin
        state_next       = state_reg;
        redirect_pc_next = redirect_pc_reg;
        redirect_valid   = 1'b0;
        flush_if_id      = 1'b0;
        flush_id_ex      = 1'b0;
        case (state_reg)
            BP_RUN: begin
                if (recover) begin
                    state_next       = BP_FLUSH;
                    redirect_pc_next = ex_target;
                end
            end
            BP_FLUSH: begin
                redirect_valid = 1'b1;
                flush_if_id    = 1'b1;
                flush_id_ex    = 1'b1;
                if (!stall) state_next = BP_RUN;
            end
            default: state_next = BP_RUN;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg       <= BP_RUN;
            redirect_pc_reg <= '0;
            br_count_reg    <= '0;
            mis_count_reg   <= '0;
        end else begin
            state_reg       <= state_next;
            redirect_pc_reg <= redirect_pc_next;
            if (train_en && (br_count_reg != '1)) br_count_reg <= br_count_reg + CNT_W'(1);
            if (recover && (mis_count_reg != '1)) mis_count_reg <= mis_count_reg + CNT_W'(1);
        end
    end

    assign redirect_pc = redirect_pc_reg;
    assign br_count    = br_count_reg;
    assign mis_count   = mis_count_reg;

endmodule

// File: tb/tb_branch_predict_ctrl.sv
// Self-checking bench for branch_predict_ctrl: directed scenarios followed by
// random traffic, all compared against a behavioural model kept in the bench.
module tb_branch_predict_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stall = 1'b0;
    logic [31:0] if_pc = '0;
    logic        ex_valid = 1'b0;
    logic        ex_is_branch = 1'b0;
    logic [31:0] ex_br_pc = '0;
    logic        ex_taken = 1'b0;
    logic        ex_correct = 1'b1;
    logic [31:0] ex_target = '0;

    logic        pred_taken, redirect_valid, flush_if_id, flush_id_ex;
    logic [31:0] redirect_pc, br_count, mis_count;
    logic        s_pred_taken, s_redirect_valid, s_flush_if_id, s_flush_id_ex;
    logic [31:0] s_redirect_pc;
    logic [2:0]  s_br_count, s_mis_count;

    int checks = 0;
    int errors = 0;

    // Behavioural model
    int          m_bht[64];
    longint      m_br, m_mis;
    bit          m_flush;
    logic [31:0] m_rpc;

    always #5 clk = ~clk;

    branch_predict_ctrl dut (
        .clk(clk), .rst(rst), .stall(stall), .if_pc(if_pc), .pred_taken(pred_taken),
        .ex_valid(ex_valid), .ex_is_branch(ex_is_branch), .ex_br_pc(ex_br_pc),
        .ex_taken(ex_taken), .ex_correct(ex_correct), .ex_target(ex_target),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .flush_if_id(flush_if_id), .flush_id_ex(flush_id_ex),
        .br_count(br_count), .mis_count(mis_count)
    );

    // Narrow-counter instance: shows saturation at all-ones without preloading.
    branch_predict_ctrl #(.BHT_INDEX_W(6), .CNT_W(3)) dut_sat (
        .clk(clk), .rst(rst), .stall(stall), .if_pc(if_pc), .pred_taken(s_pred_taken),
        .ex_valid(ex_valid), .ex_is_branch(ex_is_branch), .ex_br_pc(ex_br_pc),
        .ex_taken(ex_taken), .ex_correct(ex_correct), .ex_target(ex_target),
        .redirect_valid(s_redirect_valid), .redirect_pc(s_redirect_pc),
        .flush_if_id(s_flush_if_id), .flush_id_ex(s_flush_id_ex),
        .br_count(s_br_count), .mis_count(s_mis_count)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        foreach (m_bht[i]) m_bht[i] = 1;
        m_br = 0; m_mis = 0; m_flush = 0; m_rpc = '0;
    endtask

    function automatic bit m_pred(input logic [31:0] pc);
        return m_bht[pc[7:2]] >= 2;
    endfunction

    // Applies the current inputs to the model, then advances one clock.
    task automatic tick();
        bit ev;
        ev = ex_valid && !m_flush && !stall;
        if (m_flush) begin
            if (!stall) m_flush = 0;
        end else if (ev) begin
            if (ex_is_branch) begin
                if (ex_taken) m_bht[ex_br_pc[7:2]] = (m_bht[ex_br_pc[7:2]] < 3) ? m_bht[ex_br_pc[7:2]] + 1 : 3;
                else          m_bht[ex_br_pc[7:2]] = (m_bht[ex_br_pc[7:2]] > 0) ? m_bht[ex_br_pc[7:2]] - 1 : 0;
                m_br++;
            end
            if (!ex_correct) begin
                m_mis++;
                m_rpc = ex_target;
                m_flush = 1;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic check_all(input string tag);
        longint sat_br, sat_mis;
        sat_br  = (m_br  > 7) ? 7 : m_br;
        sat_mis = (m_mis > 7) ? 7 : m_mis;
        chk({tag, ".redirect_valid"}, 64'(redirect_valid), 64'(m_flush));
        chk({tag, ".flush_if_id"},    64'(flush_if_id),    64'(m_flush));
        chk({tag, ".flush_id_ex"},    64'(flush_id_ex),    64'(m_flush));
        chk({tag, ".redirect_pc"},    64'(redirect_pc),    64'(m_rpc));
        chk({tag, ".br_count"},       64'(br_count),       64'(m_br));
        chk({tag, ".mis_count"},      64'(mis_count),      64'(m_mis));
        chk({tag, ".pred_taken"},     64'(pred_taken),     64'(m_pred(if_pc)));
        chk({tag, ".sat_br_count"},   64'(s_br_count),     64'(sat_br));
        chk({tag, ".sat_mis_count"},  64'(s_mis_count),    64'(sat_mis));
    endtask

    task automatic check_pred(input string tag, input logic [31:0] pc, input bit exp);
        if_pc = pc;
        #1;
        chk(tag, 64'(pred_taken), 64'(exp));
        chk({tag, ".model"}, 64'(pred_taken), 64'(m_pred(pc)));
    endtask

    task automatic set_ex(input bit v, input bit br, input logic [31:0] pc,
                          input bit tk, input bit ok, input logic [31:0] tgt);
        ex_valid = v; ex_is_branch = br; ex_br_pc = pc;
        ex_taken = tk; ex_correct = ok; ex_target = tgt;
    endtask

    initial begin
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;

        // Some activity, then a reset pulse mid-simulation
        set_ex(1, 1, 32'h40, 1, 0, 32'h2000);
        tick(); tick();
        set_ex(0, 0, 0, 0, 1, 0);
        tick();
        #2 rst = 1'b1;
        model_reset();
        #1;
        check_all("reset");
        for (int i = 0; i < 64; i++) begin
            if_pc = 32'(i) << 2;
            #1;
            chk("reset.pred_taken", 64'(pred_taken), 64'd0);
        end
        @(negedge clk);
        rst = 1'b0;
        tick();
        check_all("reset.after");
        chk("reset.br_count", 64'(br_count), 64'd0);

        // Training at 0x40 with aliasing at 0x140
        set_ex(1, 1, 32'h40, 1, 1, 0);
        tick();
        check_pred("train.t1", 32'h40, 1);
        check_pred("train.alias", 32'h140, 1);
        tick(); tick();
        check_pred("train.t3", 32'h40, 1);
        set_ex(1, 1, 32'h40, 0, 1, 0);
        tick();
        check_pred("train.nt1", 32'h40, 1);
        tick();
        check_pred("train.nt2", 32'h40, 0);
        check_pred("train.alias_nt", 32'h140, 0);
        set_ex(0, 0, 0, 0, 1, 0);
        tick();
        check_all("train.end");
        chk("train.br_count", 64'(br_count), 64'd5);

        // Mispredict: redirect/flush one cycle after EX sees it, for one cycle
        set_ex(1, 1, 32'h80, 1, 0, 32'h1000);
        tick();
        set_ex(0, 0, 0, 0, 1, 0);
        chk("mis.redirect_valid", 64'(redirect_valid), 64'd1);
        chk("mis.redirect_pc", 64'(redirect_pc), 64'h1000);
        chk("mis.flush_if_id", 64'(flush_if_id), 64'd1);
        chk("mis.flush_id_ex", 64'(flush_id_ex), 64'd1);
        chk("mis.mis_count", 64'(mis_count), 64'd1);
        check_all("mis.t1");
        tick();
        chk("mis.t2_redirect_valid", 64'(redirect_valid), 64'd0);
        check_all("mis.t2");

        // Stall in FLUSH with a wrong-path mispredicting branch in EX
        set_ex(1, 0, 32'h0, 0, 0, 32'h3000);
        tick();
        set_ex(1, 1, 32'h40, 1, 0, 32'h4000);
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            check_all("stall.hold");
            chk("stall.redirect_pc", 64'(redirect_pc), 64'h3000);
            tick();
        end
        stall = 1'b0;
        check_all("stall.last");
        chk("stall.last_valid", 64'(redirect_valid), 64'd1);
        set_ex(0, 0, 0, 0, 1, 0);
        tick();
        check_all("stall.done");
        chk("stall.mis_count", 64'(mis_count), 64'd2);
        check_pred("stall.bht", 32'h40, 0);

        // Reset during FLUSH aborts the recovery at once
        set_ex(1, 0, 0, 0, 0, 32'h5000);
        tick();
        set_ex(0, 0, 0, 0, 1, 0);
        check_all("rstflush.pre");
        #2 rst = 1'b1;
        model_reset();
        #1;
        check_all("rstflush.async");
        @(negedge clk);
        rst = 1'b0;
        tick();
        check_all("rstflush.after");
        chk("rstflush.redirect_pc", 64'(redirect_pc), 64'd0);

        // Random traffic against the model
        for (int n = 0; n < 600; n++) begin
            logic [31:0] pcs[4];
            pcs[0] = 32'h40; pcs[1] = 32'h140; pcs[2] = 32'h80;
            pcs[3] = $urandom() & 32'h0000_0FFC;
            stall = ($urandom_range(0, 9) == 0);
            set_ex($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
                   pcs[$urandom_range(0, 3)], 1'($urandom()),
                   $urandom_range(0, 4) != 0, $urandom() & 32'hFFFF_FFFC);
            if_pc = pcs[$urandom_range(0, 3)];
            #1;
            chk("rand.pred_pre", 64'(pred_taken), 64'(m_pred(if_pc)));
            tick();
            check_all("rand");
        end
        stall = 1'b0;
        chk("sat.br_count", 64'(s_br_count), 64'd7);
        chk("sat.mis_count", 64'(s_mis_count), 64'd7);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
